// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: stage status into the controller, stall/bubble strobes out.
interface pipe_ctrl_if;
   logic [3:0] D_icode;
   logic [3:0] E_icode;
   logic [3:0] M_icode;
   logic [3:0] W_icode;
   logic [3:0] d_srcA;
   logic [3:0] d_srcB;
   logic [3:0] E_dstM;
   logic       e_Cnd;
   logic [3:0] m_stat;
   logic [3:0] W_stat;

   logic       F_stall;
   logic       D_stall;
   logic       W_stall;
   logic       D_bubble;
   logic       E_bubble;
   logic       M_bubble;
   logic       W_bubble;
   logic       set_cc;

   modport master (
      input  D_icode, E_icode, M_icode, W_icode, d_srcA, d_srcB, E_dstM, e_Cnd, m_stat, W_stat,
      output F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, W_bubble, set_cc
   );

   modport slave (
      output D_icode, E_icode, M_icode, W_icode, d_srcA, d_srcB, E_dstM, e_Cnd, m_stat, W_stat,
      input  F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, W_bubble, set_cc
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard strobes, run state (flush/run/halt/fault)
// and saturating performance counters.
module pipe_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 4,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   pipe_ctrl_if.master      pif,
   output logic [3:0]       cpu_stat,
   output logic             halted,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [CNT_W-1:0] lu_cnt,
   output logic [CNT_W-1:0] mp_cnt
);
   typedef enum logic [1:0] {S_INIT, S_RUN, S_HALTED, S_FAULT} state_t;

   localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

   state_t     state;
   logic [2:0] flush_cnt;
   logic [3:0] fault_stat;
   logic       lu;
   logic       mp;
   logic       ret;
   logic       m_exc;
   logic       w_exc;

   function automatic logic exc(input logic [3:0] s);
      return (s == 4'd2) || (s == 4'd3) || (s == 4'd4);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      lu    = ((pif.E_icode == 4'h5) || (pif.E_icode == 4'hB)) && (pif.E_dstM != 4'hF) &&
              ((pif.E_dstM == pif.d_srcA) || (pif.E_dstM == pif.d_srcB));
      mp    = (pif.E_icode == 4'h7) && !pif.e_Cnd;
      ret   = (pif.D_icode == 4'h9) || (pif.E_icode == 4'h9) || (pif.M_icode == 4'h9);
      m_exc = exc(pif.m_stat);
      w_exc = exc(pif.W_stat);
   end

   always_comb begin
      pif.F_stall  = 1'b0;
      pif.D_stall  = 1'b0;
      pif.W_stall  = 1'b0;
      pif.D_bubble = 1'b0;
      pif.E_bubble = 1'b0;
      pif.M_bubble = 1'b0;
      pif.W_bubble = 1'b0;
      pif.set_cc   = 1'b0;
      case (state)
         S_INIT: begin
            pif.F_stall  = 1'b1;
            pif.D_bubble = 1'b1;
            pif.E_bubble = 1'b1;
            pif.M_bubble = 1'b1;
            pif.W_bubble = 1'b1;
         end
         S_RUN: begin
            pif.F_stall  = lu | ret;
            pif.D_stall  = lu;
            // A load-use stall on D takes priority over the RET bubble
            pif.D_bubble = mp | (!lu & ret);
            pif.E_bubble = mp | lu;
            pif.M_bubble = m_exc | w_exc;
            pif.W_stall  = w_exc;
            pif.set_cc   = (pif.E_icode == 4'h6) & !m_exc & !w_exc;
         end
         default: begin
            pif.F_stall  = 1'b1;
            pif.D_stall  = 1'b1;
            pif.W_stall  = 1'b1;
            pif.E_bubble = 1'b1;
            pif.M_bubble = 1'b1;
         end
      endcase
   end

   always_comb begin
      cpu_stat = 4'd1;
      case (state)
         S_HALTED: cpu_stat = 4'd2;
         S_FAULT:  cpu_stat = fault_stat;
         default:  cpu_stat = 4'd1;
      endcase
      halted = (state == S_HALTED) || (state == S_FAULT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_INIT;
         flush_cnt  <= '0;
         fault_stat <= 4'd1;
         cyc_cnt    <= '0;
         instr_cnt  <= '0;
         lu_cnt     <= '0;
         mp_cnt     <= '0;
      end else begin
         case (state)
            S_INIT: begin
               flush_cnt <= flush_cnt + 3'd1;
               if (flush_cnt == FLUSH_LAST)
                  state <= S_RUN;
            end
            S_RUN: begin
               cyc_cnt <= sat_inc(cyc_cnt);
               if ((pif.W_stat == 4'd1) && (pif.W_icode != 4'h1))
                  instr_cnt <= sat_inc(instr_cnt);
               if (lu)
                  lu_cnt <= sat_inc(lu_cnt);
               if (mp)
                  mp_cnt <= sat_inc(mp_cnt);
               if (pif.W_stat == 4'd2) begin
                  state <= S_HALTED;
               end else if ((pif.W_stat == 4'd3) || (pif.W_stat == 4'd4)) begin
                  state      <= S_FAULT;
                  fault_stat <= pif.W_stat;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard/fault/reset cases plus random traffic,
// checked against a rule-level model; a 4-bit-counter instance covers saturation.
module tb_pipe_ctrl;
   localparam int unsigned FLUSH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0] D_icode, E_icode, M_icode, W_icode, d_srcA, d_srcB, E_dstM, m_stat, W_stat;
   logic       e_Cnd;

   pipe_ctrl_if ifa ();
   pipe_ctrl_if ifb ();

   assign ifa.D_icode = D_icode;  assign ifb.D_icode = D_icode;
   assign ifa.E_icode = E_icode;  assign ifb.E_icode = E_icode;
   assign ifa.M_icode = M_icode;  assign ifb.M_icode = M_icode;
   assign ifa.W_icode = W_icode;  assign ifb.W_icode = W_icode;
   assign ifa.d_srcA  = d_srcA;   assign ifb.d_srcA  = d_srcA;
   assign ifa.d_srcB  = d_srcB;   assign ifb.d_srcB  = d_srcB;
   assign ifa.E_dstM  = E_dstM;   assign ifb.E_dstM  = E_dstM;
   assign ifa.e_Cnd   = e_Cnd;    assign ifb.e_Cnd   = e_Cnd;
   assign ifa.m_stat  = m_stat;   assign ifb.m_stat  = m_stat;
   assign ifa.W_stat  = W_stat;   assign ifb.W_stat  = W_stat;

   logic [3:0]  stat_a, stat_b;
   logic        halted_a, halted_b;
   logic [31:0] cyc_a, instr_a, lu_a, mp_a;
   logic [3:0]  cyc_b, instr_b, lu_b, mp_b;

   pipe_ctrl #(.FLUSH_CYCLES(FLUSH), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .pif(ifa), .cpu_stat(stat_a), .halted(halted_a),
      .cyc_cnt(cyc_a), .instr_cnt(instr_a), .lu_cnt(lu_a), .mp_cnt(mp_a)
   );

   pipe_ctrl #(.FLUSH_CYCLES(FLUSH), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .pif(ifb), .cpu_stat(stat_b), .halted(halted_b),
      .cyc_cnt(cyc_b), .instr_cnt(instr_b), .lu_cnt(lu_b), .mp_cnt(mp_b)
   );

   // Model: flush cycles remaining, stop flag with its status code, unbounded event counts
   int     flush_left;
   bit     stopped;
   int     stop_code;
   longint n_cyc, n_instr, n_lu, n_mp;
   int     n_assert = 0;
   int     n_fail   = 0;

   function automatic bit is_exc(input int s);
      return (s == 2) || (s == 3) || (s == 4);
   endfunction

   function automatic bit load_use();
      return (E_icode == 5 || E_icode == 11) && E_dstM != 15 && (E_dstM == d_srcA || E_dstM == d_srcB);
   endfunction

   function automatic bit mispredict();
      return E_icode == 7 && e_Cnd == 1'b0;
   endfunction

   function automatic bit has_ret();
      return D_icode == 9 || E_icode == 9 || M_icode == 9;
   endfunction

   function automatic longint sat4(input longint v);
      return (v > 15) ? 15 : v;
   endfunction

   // Packed as {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble, set_cc}
   function automatic logic [7:0] exp_strobes();
      bit lu, mp, rt, me, we;
      if (flush_left > 0) return 8'b1011_1010;
      if (stopped)        return 8'b1101_1100;
      lu = load_use(); mp = mispredict(); rt = has_ret();
      me = is_exc(int'(m_stat)); we = is_exc(int'(W_stat));
      return {lu | rt, lu, mp | (!lu & rt), mp | lu, me | we, we, 1'b0,
              (E_icode == 6) & !me & !we};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [7:0] e;
      e = exp_strobes();
      chk({tag, "/strobes_a"}, 64'({ifa.F_stall, ifa.D_stall, ifa.D_bubble, ifa.E_bubble,
                                    ifa.M_bubble, ifa.W_stall, ifa.W_bubble, ifa.set_cc}), 64'(e));
      chk({tag, "/strobes_b"}, 64'({ifb.F_stall, ifb.D_stall, ifb.D_bubble, ifb.E_bubble,
                                    ifb.M_bubble, ifb.W_stall, ifb.W_bubble, ifb.set_cc}), 64'(e));
      chk({tag, "/d_stall_and_bubble"}, 64'(ifa.D_stall & ifa.D_bubble), 64'(0));
      chk({tag, "/cpu_stat"}, 64'(stat_a), 64'(stopped ? stop_code : 1));
      chk({tag, "/halted"}, 64'(halted_a), 64'(stopped));
      chk({tag, "/cpu_stat_b"}, 64'(stat_b), 64'(stopped ? stop_code : 1));
      chk({tag, "/cyc_cnt"}, 64'(cyc_a), 64'(n_cyc));
      chk({tag, "/instr_cnt"}, 64'(instr_a), 64'(n_instr));
      chk({tag, "/lu_cnt"}, 64'(lu_a), 64'(n_lu));
      chk({tag, "/mp_cnt"}, 64'(mp_a), 64'(n_mp));
      chk({tag, "/cyc_cnt_sat"}, 64'(cyc_b), 64'(sat4(n_cyc)));
      chk({tag, "/instr_cnt_sat"}, 64'(instr_b), 64'(sat4(n_instr)));
      chk({tag, "/lu_cnt_sat"}, 64'(lu_b), 64'(sat4(n_lu)));
      chk({tag, "/mp_cnt_sat"}, 64'(mp_b), 64'(sat4(n_mp)));
   endtask

   task automatic model_reset();
      flush_left = FLUSH;
      stopped = 1'b0; stop_code = 1;
      n_cyc = 0; n_instr = 0; n_lu = 0; n_mp = 0;
   endtask

   task automatic model_edge();
      if (flush_left > 0) begin
         flush_left--;
      end else if (!stopped) begin
         n_cyc++;
         if (W_stat == 1 && W_icode != 1) n_instr++;
         if (load_use())   n_lu++;
         if (mispredict()) n_mp++;
         if (is_exc(int'(W_stat))) begin
            stopped = 1'b1;
            stop_code = int'(W_stat);
         end
      end
   endtask

   task automatic set_idle();
      D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
      d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
      e_Cnd = 1'b1; m_stat = 4'd1; W_stat = 4'd1;
   endtask

   task automatic set_random();
      int unsigned ecodes [8] = '{5, 11, 7, 6, 9, 1, 2, 3};
      D_icode = 4'($urandom_range(0, 11));
      E_icode = 4'(ecodes[$urandom_range(0, 7)]);
      M_icode = 4'($urandom_range(0, 11));
      W_icode = 4'($urandom_range(0, 11));
      d_srcA  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      d_srcB  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      E_dstM  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      e_Cnd   = 1'($urandom_range(0, 1));
      m_stat  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
      W_stat  = ($urandom_range(0, 59) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
   endtask

   // Called just after a falling edge: check the present cycle, then advance one edge
   task automatic cycle(input string tag);
      #1;
      check_all(tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   // Reset asserts between edges so the checks see the asynchronous effect
   task automatic do_reset();
      #2 rst = 1'b1;
      model_reset();
      #1 check_all("reset");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      set_idle();
      model_reset();
      @(negedge clk);
      do_reset();

      for (int i = 0; i < int'(FLUSH); i++) cycle("flush");

      set_idle(); E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
      cycle("load_use");
      chk("lu_cnt_after_load_use", 64'(lu_a), 64'(1));
      E_dstM = 4'hF; d_srcA = 4'hF;
      cycle("load_use_none");

      set_idle(); E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9;
      cycle("mispredict_ret");
      chk("mp_cnt_after_mispredict", 64'(mp_a), 64'(1));

      set_idle(); E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2; M_icode = 4'h9;
      cycle("load_use_ret");

      set_idle();
      for (int i = 0; i < 10; i++) begin
         W_icode = (i % 2 == 0) ? 4'h6 : 4'h1;
         cycle("retire");
      end
      chk("instr_cnt_retire", 64'(instr_a), 64'(5));

      set_idle(); E_icode = 4'h6; m_stat = 4'd3;
      cycle("set_cc_masked");
      m_stat = 4'd1;
      cycle("set_cc_open");

      set_idle();
      for (int i = 0; i < 6; i++) cycle("saturate");
      chk("cyc_cnt_saturated", 64'(cyc_b), 64'(15));

      W_stat = 4'd4;
      cycle("fault_entry");
      W_stat = 4'd1;
      for (int i = 0; i < 3; i++) cycle("fault_sticky");
      chk("fault_cpu_stat", 64'(stat_a), 64'(4));

      do_reset();
      for (int i = 0; i < int'(FLUSH); i++) cycle("flush2");
      for (int i = 0; i < 20; i++) cycle("run20");
      W_stat = 4'd2;
      cycle("halt_entry");
      W_stat = 4'd1;
      cycle("halt_sticky");

      for (int ep = 0; ep < 8; ep++) begin
         set_idle();
         do_reset();
         for (int i = 0; i < int'(FLUSH); i++) begin
            set_random();
            cycle("rand_flush");
         end
         for (int i = 0; i < 80; i++) begin
            set_random();
            cycle("rand_run");
         end
      end

      set_idle();
      do_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
